// File: rtl/qam_mapper_if.sv
// Bit-stream in / constellation-point out bundle for the 802.11a subcarrier mapper.
// The master drives the coded bit stream and rate; the slave (mapper) returns I/Q points.
interface qam_mapper_if #(parameter int W = 8);
    logic                x;
    logic                InValid;
    logic [3:0]          Rate;
    logic signed [W-1:0] I;
    logic signed [W-1:0] Q;
    logic                OutValid;
    logic [5:0]          SubIdx;
    logic                SymEnd;
    logic                RateErr;

    modport master (output x, InValid, Rate,
                    input  I, Q, OutValid, SubIdx, SymEnd, RateErr);
    modport slave  (input  x, InValid, Rate,
                    output I, Q, OutValid, SubIdx, SymEnd, RateErr);
endinterface

// File: rtl/qam_mapper.sv
// 802.11a subcarrier mapper: groups Nbpsc interleaved bits into one Kmod-scaled,
// Gray-mapped I/Q point and counts 48 data subcarriers per OFDM symbol.
module qam_mapper #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    qam_mapper_if.slave  bus
);

    logic [3:0] rate_l;
    logic [2:0] bit_cnt;
    logic [4:0] grp;
    logic [5:0] grp_nxt;
    logic [5:0] sub_cnt;
    logic [2:0] last_bit;
    logic       legal;
    logic signed [7:0] i_lv, q_lv;

    function automatic logic signed [7:0] lv_qpsk(input logic b);
        return b ? 8'sd45 : -8'sd45;
    endfunction

    function automatic logic signed [7:0] lv_16(input logic [1:0] g);
        case (g)
            2'b00:   return -8'sd61;
            2'b01:   return -8'sd20;
            2'b11:   return  8'sd20;
            default: return  8'sd61;
        endcase
    endfunction

    function automatic logic signed [7:0] lv_64(input logic [2:0] g);
        case (g)
            3'b000:  return -8'sd69;
            3'b001:  return -8'sd49;
            3'b011:  return -8'sd30;
            3'b010:  return -8'sd10;
            3'b110:  return  8'sd10;
            3'b111:  return  8'sd30;
            3'b101:  return  8'sd49;
            default: return  8'sd69;
        endcase
    endfunction

    always_comb begin
        legal    = 1'b1;
        last_bit = 3'd0;
        case (rate_l)
            4'b1101, 4'b1111: last_bit = 3'd0;
            4'b0101, 4'b0111: last_bit = 3'd1;
            4'b1001, 4'b1011: last_bit = 3'd3;
            4'b0001, 4'b0011: last_bit = 3'd5;
            default:          legal    = 1'b0;
        endcase
    end

    // Shift left so the first-received bit b0 ends up as the MSB of the group window
    assign grp_nxt = {grp, bus.x};

    always_comb begin
        i_lv = '0;
        q_lv = '0;
        case (last_bit)
            3'd0: i_lv = grp_nxt[0] ? 8'sd64 : -8'sd64;
            3'd1: begin
                i_lv = lv_qpsk(grp_nxt[1]);
                q_lv = lv_qpsk(grp_nxt[0]);
            end
            3'd3: begin
                i_lv = lv_16(grp_nxt[3:2]);
                q_lv = lv_16(grp_nxt[1:0]);
            end
            default: begin
                i_lv = lv_64(grp_nxt[5:3]);
                q_lv = lv_64(grp_nxt[2:0]);
            end
        endcase
    end

    assign bus.RateErr = ~legal;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rate_l       <= 4'b0011;
            bit_cnt      <= '0;
            grp          <= '0;
            sub_cnt      <= '0;
            bus.I        <= '0;
            bus.Q        <= '0;
            bus.OutValid <= 1'b0;
            bus.SubIdx   <= '0;
            bus.SymEnd   <= 1'b0;
        end else if (!Start) begin
            rate_l       <= bus.Rate;
            bit_cnt      <= '0;
            grp          <= '0;
            sub_cnt      <= '0;
            bus.I        <= '0;
            bus.Q        <= '0;
            bus.OutValid <= 1'b0;
            bus.SubIdx   <= '0;
            bus.SymEnd   <= 1'b0;
        end else begin
            bus.OutValid <= 1'b0;
            bus.SymEnd   <= 1'b0;
            // Rate may only change on an OFDM symbol boundary
            if (bit_cnt == 3'd0 && sub_cnt == 6'd0)
                rate_l <= bus.Rate;
            if (bus.InValid && legal) begin
                grp <= grp_nxt[4:0];
                if (bit_cnt == last_bit) begin
                    bit_cnt      <= '0;
                    bus.I        <= W'(i_lv);
                    bus.Q        <= W'(q_lv);
                    bus.OutValid <= 1'b1;
                    bus.SubIdx   <= sub_cnt;
                    bus.SymEnd   <= (sub_cnt == 6'd47);
                    sub_cnt      <= (sub_cnt == 6'd47) ? 6'd0 : sub_cnt + 6'd1;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qam_mapper.sv
// Self-checking bench for qam_mapper: random bit groups scored against a Gray-decode level model.
module tb_qam_mapper;

    logic Clk = 1'b0;
    logic Reset;
    logic Start;

    qam_mapper_if #(.W(8)) bus();
    qam_mapper #(.W(8)) dut (.Clk(Clk), .Reset(Reset), .Start(Start), .bus(bus));

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic signed [7:0] i;
        logic signed [7:0] q;
        logic [5:0]        idx;
        logic              se;
    } pt_t;

    pt_t cap[$];
    pt_t exp_q[$];
    int  cap_cyc[$];
    int  cyc = 0;
    int  stray = 0;
    int  last_edge = 0;
    int  checks = 0;
    int  failures = 0;

    // Amplitude ladders indexed by Gray-decoded position, most negative first
    int L16[4] = '{-61, -20, 20, 61};
    int L64[8] = '{-69, -49, -30, -10, 10, 30, 49, 69};

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (bus.OutValid) begin
            pt_t p;
            p.i = bus.I; p.q = bus.Q; p.idx = bus.SubIdx; p.se = bus.SymEnd;
            cap.push_back(p);
            cap_cyc.push_back(cyc);
        end
        if (bus.SymEnd && !bus.OutValid) stray++;
    end

    function automatic int gray(logic [5:0] b, int lo, int n);
        int   k = 0;
        logic a = 1'b0;
        for (int j = 0; j < n; j++) begin
            a = a ^ b[lo+j];
            k = 2 * k + int'(a);
        end
        return k;
    endfunction

    // b[0] is the first bit sent in the group
    function automatic pt_t ref_pt(int nb, logic [5:0] b, int idx);
        int  iv, qv;
        pt_t p;
        iv = 0; qv = 0;
        case (nb)
            1: iv = b[0] ? 64 : -64;
            2: begin iv = b[0] ? 45 : -45; qv = b[1] ? 45 : -45; end
            4: begin iv = L16[gray(b, 0, 2)]; qv = L16[gray(b, 2, 2)]; end
            default: begin iv = L64[gray(b, 0, 3)]; qv = L64[gray(b, 3, 3)]; end
        endcase
        p.i = iv[7:0]; p.q = qv[7:0]; p.idx = idx[5:0]; p.se = (idx == 47);
        return p;
    endfunction

    task automatic idle(int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic send_bit(logic b, int gap);
        bus.x = b; bus.InValid = 1'b1;
        @(posedge Clk); #1;
        last_edge = cyc;
        bus.InValid = 1'b0; bus.x = 1'b0;
        idle(gap);
    endtask

    task automatic send_group(int nb, logic [5:0] b, int gap);
        for (int j = 0; j < nb; j++) send_bit(b[j], gap);
    endtask

    task automatic clear_to(logic [3:0] rate);
        bus.Rate = rate; Start = 1'b0;
        idle(1);
        Start = 1'b1;
        idle(1);
        cap.delete(); cap_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        logic [5:0] b;
        Reset = 1'b1; Start = 1'b1; bus.x = 1'b0; bus.InValid = 1'b0; bus.Rate = 4'b0001;
        idle(2);
        checks++;
        if ({bus.I, bus.Q, bus.SubIdx} !== 22'd0) begin
            failures++; $display("FAIL reset_iq got=%h want=0", {bus.I, bus.Q, bus.SubIdx});
        end
        checks++;
        if ({bus.OutValid, bus.SymEnd, bus.RateErr} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b want=000", {bus.OutValid, bus.SymEnd, bus.RateErr});
        end
        Reset = 1'b0;
        idle(2);
        for (int k = 0; k < 14; k++) send_bit(1'($urandom), 0);
        // Assert reset between edges while a bit is being presented
        bus.x = 1'b1; bus.InValid = 1'b1;
        #3 Reset = 1'b1;
        #1;
        checks++;
        if ({bus.I, bus.Q, bus.SubIdx, bus.OutValid, bus.SymEnd} !== 24'd0) begin
            failures++; $display("FAIL reset_async got=%h want=0", {bus.I, bus.Q, bus.SubIdx, bus.OutValid, bus.SymEnd});
        end
        bus.InValid = 1'b0; bus.x = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        idle(1);
        cap.delete(); cap_cyc.delete(); exp_q.delete();
        b = 6'($urandom);
        send_group(6, b, 0);
        exp_q.push_back(ref_pt(6, b, 0));
        idle(2);
        checks++;
        if (cap.size() != 1) begin
            failures++; $display("FAIL reset_resume_count got=%0d want=1", cap.size());
        end else begin
            checks++;
            if (cap[0] !== exp_q[0]) begin
                failures++; $display("FAIL reset_resume_pt got=%h want=%h", cap[0], exp_q[0]);
            end
            checks++;
            if (cap_cyc[0] != last_edge) begin
                failures++; $display("FAIL reset_resume_lat got=%0d want=%0d", cap_cyc[0], last_edge);
            end
        end
    endtask

    task automatic test_bpsk();
        int first_edge;
        clear_to(4'b1101);
        first_edge = 0;
        for (int k = 0; k < 48; k++) begin
            logic [5:0] b;
            b = (k % 2 == 0) ? 6'd1 : 6'd0;
            exp_q.push_back(ref_pt(1, b, k));
            send_bit(b[0], 0);
            if (k == 0) first_edge = last_edge;
        end
        idle(2);
        checks++;
        if (cap.size() != 48) begin
            failures++; $display("FAIL bpsk_count got=%0d want=48", cap.size());
        end
        for (int k = 0; k < 48 && k < cap.size(); k++) begin
            checks++;
            if (cap[k] !== exp_q[k]) begin
                failures++; $display("FAIL bpsk_pt%0d got=%h want=%h", k, cap[k], exp_q[k]);
            end
            if (k > 0) begin
                checks++;
                if (cap_cyc[k] != cap_cyc[k-1] + 1) begin
                    failures++; $display("FAIL bpsk_rate%0d got=%0d want=%0d", k, cap_cyc[k], cap_cyc[k-1] + 1);
                end
            end
        end
        if (cap.size() > 0) begin
            checks++;
            if (cap_cyc[0] != first_edge) begin
                failures++; $display("FAIL bpsk_latency got=%0d want=%0d", cap_cyc[0], first_edge);
            end
        end
    endtask

    task automatic test_qam16_gaps();
        logic [5:0] b;
        clear_to(4'b1001);
        b = 6'b001011;
        send_group(4, b, 3);
        exp_q.push_back(ref_pt(4, b, 0));
        checks++;
        if (cap.size() != 1 || cap_cyc[0] != last_edge) begin
            failures++; $display("FAIL q16_gap_strobe got=%0d pts want=1 at cycle %0d", cap.size(), last_edge);
        end
        for (int k = 1; k <= 8; k++) begin
            b = 6'($urandom);
            send_group(4, b, $urandom_range(0, 3));
            exp_q.push_back(ref_pt(4, b, k));
        end
        idle(2);
        checks++;
        if (cap.size() != exp_q.size()) begin
            failures++; $display("FAIL q16_count got=%0d want=%0d", cap.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < cap.size(); k++) begin
            checks++;
            if (cap[k] !== exp_q[k]) begin
                failures++; $display("FAIL q16_pt%0d got=%h want=%h", k, cap[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_qam64_symbol();
        logic [5:0] b;
        clear_to(4'b0001);
        for (int k = 0; k < 48; k++) begin
            b = 6'b000001;
            send_group(6, b, 0);
            exp_q.push_back(ref_pt(6, b, k));
        end
        b = 6'($urandom);
        send_group(6, b, 0);
        exp_q.push_back(ref_pt(6, b, 0));
        idle(2);
        checks++;
        if (cap.size() != 49) begin
            failures++; $display("FAIL q64_count got=%0d want=49", cap.size());
        end
        for (int k = 0; k < exp_q.size() && k < cap.size(); k++) begin
            checks++;
            if (cap[k] !== exp_q[k]) begin
                failures++; $display("FAIL q64_pt%0d got=%h want=%h", k, cap[k], exp_q[k]);
            end
        end
        checks++;
        if (stray != 0) begin
            failures++; $display("FAIL symend_stray got=%0d want=0", stray);
        end
    endtask

    task automatic test_rate_change();
        logic [5:0] b;
        clear_to(4'b0101);
        for (int k = 0; k < 48; k++) begin
            if (k == 10) bus.Rate = 4'b0001;
            b = 6'($urandom);
            send_group(2, b, 0);
            exp_q.push_back(ref_pt(2, b, k));
        end
        idle(2);
        for (int k = 0; k < 5; k++) begin
            b = 6'($urandom);
            send_group(6, b, 0);
            exp_q.push_back(ref_pt(6, b, k));
        end
        idle(2);
        checks++;
        if (cap.size() != exp_q.size()) begin
            failures++; $display("FAIL rchg_count got=%0d want=%0d", cap.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < cap.size(); k++) begin
            checks++;
            if (cap[k] !== exp_q[k]) begin
                failures++; $display("FAIL rchg_pt%0d got=%h want=%h", k, cap[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] b;
        clear_to(4'b0000);
        checks++;
        if (bus.RateErr !== 1'b1) begin
            failures++; $display("FAIL illegal_err got=%b want=1", bus.RateErr);
        end
        for (int k = 0; k < 20; k++) send_bit(1'($urandom), $urandom_range(0, 1));
        idle(2);
        checks++;
        if (cap.size() != 0 || bus.RateErr !== 1'b1) begin
            failures++; $display("FAIL illegal_quiet got=%0d pts err=%b want=0 pts err=1", cap.size(), bus.RateErr);
        end
        bus.Rate = 4'b0101;
        idle(1);
        checks++;
        if (bus.RateErr !== 1'b0) begin
            failures++; $display("FAIL illegal_recover got=%b want=0", bus.RateErr);
        end
        for (int k = 0; k < 2; k++) begin
            b = 6'($urandom);
            send_group(2, b, 0);
            exp_q.push_back(ref_pt(2, b, k));
        end
        idle(2);
        checks++;
        if (cap.size() != 2) begin
            failures++; $display("FAIL illegal_qpsk_count got=%0d want=2", cap.size());
        end
        for (int k = 0; k < 2 && k < cap.size(); k++) begin
            checks++;
            if (cap[k] !== exp_q[k]) begin
                failures++; $display("FAIL illegal_qpsk_pt%0d got=%h want=%h", k, cap[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_clear();
        logic [5:0] b;
        clear_to(4'b0001);
        b = 6'($urandom);
        send_group(6, b, 0);
        exp_q.push_back(ref_pt(6, b, 0));
        for (int k = 0; k < 3; k++) send_bit(1'($urandom), 0);
        Start = 1'b0;
        idle(1);
        Start = 1'b1;
        checks++;
        if ({bus.I, bus.Q, bus.SubIdx, bus.OutValid} !== 23'd0) begin
            failures++; $display("FAIL clear_state got=%h want=0", {bus.I, bus.Q, bus.SubIdx, bus.OutValid});
        end
        b = 6'($urandom);
        send_group(6, b, 0);
        exp_q.push_back(ref_pt(6, b, 0));
        for (int k = 0; k < 5; k++) send_bit(1'($urandom), 0);
        // Last bit of the group coincides with Start low: the clear must win
        bus.x = 1'($urandom); bus.InValid = 1'b1; Start = 1'b0;
        @(posedge Clk); #1;
        bus.InValid = 1'b0; Start = 1'b1;
        idle(1);
        b = 6'($urandom);
        send_group(6, b, 0);
        exp_q.push_back(ref_pt(6, b, 0));
        idle(2);
        checks++;
        if (cap.size() != 3) begin
            failures++; $display("FAIL clear_count got=%0d want=3", cap.size());
        end
        for (int k = 0; k < 3 && k < cap.size(); k++) begin
            checks++;
            if (cap[k] !== exp_q[k]) begin
                failures++; $display("FAIL clear_pt%0d got=%h want=%h", k, cap[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bpsk();
        test_qam16_gaps();
        test_qam64_symbol();
        test_rate_change();
        test_illegal();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
